imem_boot_loader: RTL and testbench

Boot sequencer for the pipelined processor. It holds the core in reset, clears the instruction memory, and streams program words over a valid/ready handshake into consecutive instruction-memory addresses starting at a fixed base. After the last word it keeps the core in reset for a programmable number of cycles, then releases it. It sits between the program source (bench or host link) and the processor's instruction-memory write port (`*_fm` signals) and its `reset` input.

---
 rtl/imem_boot_loader.sv | 120 ++++++++++++
 tb/tb_imem_boot_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, clears instruction memory, streams
// program words into consecutive addresses from BASE_ADDR, then releases the core.
module imem_boot_loader #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h20),
    parameter int                MAX_WORDS = 1024,
    parameter int                RST_HOLD  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              write_enable_fm,
    output logic [ADDR_W-1:0] write_addr_fm,
    output logic [DATA_W-1:0] write_data_fm,
    output logic              rst_fm,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    // Count value that, once incremented by a non-final word, exhausts the program space.
    localparam logic [15:0] LAST_SLOT = 16'(MAX_WORDS - 1);
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);

    logic [2:0]        state_reg, state_next;
    logic [15:0]       word_count_reg, word_count_next;
    logic [31:0]       hold_cnt_reg, hold_cnt_next;
    logic              write_enable_reg;
    logic [ADDR_W-1:0] write_addr_reg;
    logic [DATA_W-1:0] write_data_reg;
    logic              handshake;

    assign handshake = in_valid && (state_reg == S_LOAD);

    always_comb begin
        state_next      = state_reg;
        word_count_next = word_count_reg;
        hold_cnt_next   = hold_cnt_reg;
        case (state_reg)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_next      = S_CLEAR;
                    word_count_next = 16'd0;
                end
            end
            S_CLEAR: begin
                word_count_next = 16'd0;
                state_next      = S_LOAD;
            end
            S_LOAD: begin
                if (handshake) begin
                    word_count_next = word_count_reg + 16'd1;
                    // A final word that also fills the last slot is a clean finish.
                    if (in_last) begin
                        state_next    = S_RELEASE;
                        hold_cnt_next = 32'd0;
                    end else if (word_count_reg == LAST_SLOT) begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_RELEASE: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = S_RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 32'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            word_count_reg   <= 16'd0;
            hold_cnt_reg     <= 32'd0;
            write_enable_reg <= 1'b0;
            write_addr_reg   <= BASE_ADDR;
            write_data_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            word_count_reg   <= word_count_next;
            hold_cnt_reg     <= hold_cnt_next;
            write_enable_reg <= handshake;
            // Address and data hold their last values between writes.
            if (handshake) begin
                write_addr_reg <= BASE_ADDR + ADDR_W'(word_count_reg);
                write_data_reg <= in_data;
            end
        end
    end

    assign in_ready        = (state_reg == S_LOAD);
    assign rst_fm          = (state_reg == S_CLEAR);
    assign cpu_reset       = (state_reg != S_RUN);
    assign done            = (state_reg == S_RUN);
    assign error           = (state_reg == S_ERROR);
    assign busy            = (state_reg == S_CLEAR) || (state_reg == S_LOAD) ||
                             (state_reg == S_RELEASE);
    assign write_enable_fm = write_enable_reg;
    assign write_addr_fm   = write_addr_reg;
    assign write_data_fm   = write_data_reg;
    assign word_count      = word_count_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expected writes,
// a negedge monitor pops and compares each instruction-memory write.
module tb_imem_boot_loader;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 16;
    localparam int          MAX_WORDS = 4;
    localparam int          RST_HOLD  = 2;
    localparam logic [31:0] BASE      = 32'h20;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              write_enable_fm;
    logic [ADDR_W-1:0] write_addr_fm;
    logic [DATA_W-1:0] write_data_fm;
    logic              rst_fm;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       word_count;

    imem_boot_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAX_WORDS),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .write_enable_fm(write_enable_fm),
        .write_addr_fm  (write_addr_fm),
        .write_data_fm  (write_data_fm),
        .rst_fm         (rst_fm),
        .cpu_reset      (cpu_reset),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .word_count     (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  load_idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe must match the oldest pending expected write.
    always @(negedge clk) begin
        if (write_enable_fm === 1'b1) begin : mon
            wr_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, nothing pending",
                         write_addr_fm, write_data_fm, cyc);
            end else begin
                e = exp_q.pop_front();
                if (write_addr_fm !== e.addr || write_data_fm !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h cycle %0d, expected addr 0x%0h data 0x%0h cycle %0d",
                             write_addr_fm, write_data_fm, cyc, e.addr, e.data, e.cyc);
                end else begin
                    $display("write addr 0x%0h data 0x%0h cycle %0d ok", write_addr_fm, write_data_fm, cyc);
                end
            end
        end
    end

    // Reference model: the n-th accepted word of a load goes to BASE+n, one cycle later.
    task automatic send_word(input logic [15:0] d, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            chk("handshake_timeout", 64'(in_ready), 64'd1);
        end else begin
            tick();
            exp_q.push_back('{BASE + 32'(load_idx), d, cyc});
            load_idx++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start    = 1'b0;
        load_idx = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_rst_fm", 64'(rst_fm), 64'd0);
        chk("rst_write_enable", 64'(write_enable_fm), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_write_addr", 64'(write_addr_fm), 64'(BASE));
        chk("rst_write_data", 64'(write_data_fm), 64'd0);
    endtask

    // Called in the cycle after the last handshake.
    task automatic check_release(input int n);
        @(negedge clk);
        chk("in_ready_after_last", 64'(in_ready), 64'd0);
        for (int j = 0; j <= RST_HOLD; j++) begin
            if (j > 0) begin
                tick();
                @(negedge clk);
            end
            chk("cpu_reset_hold", 64'(cpu_reset), 64'(j < RST_HOLD));
            chk("done_rise", 64'(done), 64'(j == RST_HOLD));
        end
        chk("word_count_final", 64'(word_count), 64'(n));
        chk("busy_run", 64'(busy), 64'd0);
    endtask

    task automatic check_drained();
        repeat (3) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int len;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;

        // Reset held two cycles, with start colliding on the second: reset wins.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_reset_values();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_after_reset_start", 64'(busy), 64'd0);
        chk("idle_no_clear", 64'(rst_fm), 64'd0);

        // Two-word load.
        pulse_start();
        @(negedge clk);
        chk("clear_rst_fm", 64'(rst_fm), 64'd1);
        chk("clear_busy", 64'(busy), 64'd1);
        chk("clear_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("clear_in_ready", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("load_in_ready", 64'(in_ready), 64'd1);
        chk("load_rst_fm", 64'(rst_fm), 64'd0);
        chk("load_word_count", 64'(word_count), 64'd0);
        send_word(16'h553F, 1'b0);
        send_word(16'h2ABF, 1'b1);
        check_release(2);
        check_drained();

        // Reload from RUN with a gapped three-word stream.
        pulse_start();
        @(negedge clk);
        chk("reload_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("reload_done", 64'(done), 64'd0);
        chk("reload_rst_fm", 64'(rst_fm), 64'd1);
        tick();
        @(negedge clk);
        chk("reload_rst_fm_single", 64'(rst_fm), 64'd0);
        chk("reload_word_count", 64'(word_count), 64'd0);
        for (int w = 0; w < 3; w++) begin
            send_word(16'($urandom), w == 2);
            if (w < 2) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    @(negedge clk);
                    chk("gap_no_write", 64'(write_enable_fm), 64'd0);
                end
            end
        end
        check_release(3);
        check_drained();

        // Randomized loads of 1..MAX_WORDS words with random stalls.
        for (int it = 0; it < 6; it++) begin
            pulse_start();
            tick();
            len = $urandom_range(1, MAX_WORDS);
            for (int w = 0; w < len; w++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_word(16'($urandom), w == len - 1);
            end
            check_release(len);
        end
        check_drained();

        // Overflow: MAX_WORDS words without in_last.
        pulse_start();
        tick();
        for (int w = 0; w < MAX_WORDS; w++) send_word(16'($urandom), 1'b0);
        @(negedge clk);
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_in_ready", 64'(in_ready), 64'd0);
        chk("ovf_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("ovf_done", 64'(done), 64'd0);
        chk("ovf_word_count", 64'(word_count), 64'(MAX_WORDS));
        in_valid = 1'b1;
        in_last  = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("ovf_error_sticky", 64'(error), 64'd1);
        pulse_start();
        @(negedge clk);
        chk("err_clear_error", 64'(error), 64'd0);
        chk("err_clear_rst_fm", 64'(rst_fm), 64'd1);
        tick();
        send_word(16'h1234, 1'b1);
        check_release(1);
        check_drained();

        // Reset in the middle of a load.
        pulse_start();
        tick();
        send_word(16'($urandom), 1'b0);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        tick();
        @(negedge clk);
        check_reset_values();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 64'd0);
        chk("post_reset_cpu_reset", 64'(cpu_reset), 64'd1);
        in_valid = 1'b0;
        pulse_start();
        tick();
        send_word(16'hBEEF, 1'b0);
        send_word(16'hCAFE, 1'b1);
        check_release(2);
        check_drained();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
